// File: rtl/tbird_ctrl_if.sv
// Switch inputs and light-state outputs of the Thunderbird tail-light controller.
// master: the switch side (board / testbench); slave: the controller.
interface tbird_ctrl_if;
  logic       left;
  logic       right;
  logic       brake;
  logic       hazard;
  logic [2:0] current_state;
  logic [1:0] count_lb;
  logic [1:0] count_rb;
  logic       count_h;

  modport master (
    output left, right, brake, hazard,
    input  current_state, count_lb, count_rb, count_h
  );

  modport slave (
    input  left, right, brake, hazard,
    output current_state, count_lb, count_rb, count_h
  );
endinterface

// File: rtl/tbird_ctrl.sv
// Thunderbird tail-light sequential controller: switch sampling, light-state FSM,
// free-running animation prescaler and per-group sequence counters.
// Optional macro TBIRD_INSYNC_EN: two-flop synchronizers on the four switches
// (adds two cycles of input-to-state latency).
module tbird_ctrl #(
  parameter int unsigned TICK_DIV = 12_500_000
) (
  input logic        clk,
  input logic        reset,
  tbird_ctrl_if.slave bus
);

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    IDEL    = 3'b000,
    LEFT    = 3'b001,
    RIGHT   = 3'b010,
    LBREAK  = 3'b011,
    RBREAK  = 3'b100,
    BREAK   = 3'b101,
    HAZARD  = 3'b110,
    ILLEGAL = 3'b111
  } state_t;

  state_t        state, state_n;
  logic [PW-1:0] presc;
  logic          tick;
  logic          l, r, b, h;
  logic [1:0]    count_lb, count_lb_n;
  logic [1:0]    count_rb, count_rb_n;
  logic          count_h, count_h_n;

`ifdef TBIRD_INSYNC_EN
  logic [3:0] sync1, sync2;

  // Two-flop synchronizer for the asynchronous switch levels.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {bus.hazard, bus.brake, bus.right, bus.left};
      sync2 <= sync1;
    end
  end

  assign {h, b, r, l} = sync2;
`else
  assign {h, b, r, l} = {bus.hazard, bus.brake, bus.right, bus.left};
`endif

  // Free-running animation prescaler; never restarted by a state change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
    end else if (presc == TICK_LAST) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  assign tick = (presc == TICK_LAST);

  function automatic logic in_left(input state_t s);
    return (s == LEFT) || (s == LBREAK);
  endfunction

  function automatic logic in_right(input state_t s);
    return (s == RIGHT) || (s == RBREAK);
  endfunction

  // State and sequence-counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDEL;
      count_lb <= '0;
      count_rb <= '0;
      count_h  <= 1'b0;
    end else begin
      state    <= state_n;
      count_lb <= count_lb_n;
      count_rb <= count_rb_n;
      count_h  <= count_h_n;
    end
  end

  // Next state: priority decode of the sampled switches; any state reaches any
  // other in one step, so the current state only matters for the illegal code.
  always_comb begin
    state_n = IDEL;
    if (state != ILLEGAL) begin
      if (h)                 state_n = HAZARD;
      else if (b && l && !r) state_n = LBREAK;
      else if (b && r && !l) state_n = RBREAK;
      else if (b)            state_n = BREAK;
      else if (l && !r)      state_n = LEFT;
      else if (r && !l)      state_n = RIGHT;
      else                   state_n = IDEL;
    end
  end

  // Counter updates: clear on leaving or entering a group (clear beats tick),
  // advance on tick only while staying inside the group.
  always_comb begin
    count_lb_n = count_lb;
    count_rb_n = count_rb;
    count_h_n  = count_h;

    if (!in_left(state_n) || !in_left(state)) begin
      count_lb_n = '0;
    end else if (tick) begin
      count_lb_n = count_lb + 2'd1;
    end

    if (!in_right(state_n) || !in_right(state)) begin
      count_rb_n = '0;
    end else if (tick) begin
      count_rb_n = count_rb + 2'd1;
    end

    if ((state_n != HAZARD) || (state != HAZARD)) begin
      count_h_n = 1'b0;
    end else if (tick) begin
      count_h_n = ~count_h;
    end
  end

  assign bus.current_state = state;
  assign bus.count_lb      = count_lb;
  assign bus.count_rb      = count_rb;
  assign bus.count_h       = count_h;

endmodule

// File: tb/tb_tbird_ctrl.sv
// Scoreboard bench for tbird_ctrl with TICK_DIV=4. Expectations carry the cycle
// (edges since reset release) at which they are due; the monitor compares them.
module tb_tbird_ctrl;

`ifdef TBIRD_INSYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  typedef struct {
    int         k;
    logic [2:0] st;
    logic [1:0] lb;
    logic [1:0] rb;
    logic       h;
    string      name;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   base = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  tbird_ctrl_if bus ();

  tbird_ctrl #(.TICK_DIV(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int k, input logic [2:0] st, input logic [1:0] lb,
                      input logic [1:0] rb, input logic h, input string name);
    exp_t e;
    e.k = base + k; e.st = st; e.lb = lb; e.rb = rb; e.h = h; e.name = name;
    q.push_back(e);
  endtask

  // Advance until the edge numbered k (relative to base) has passed, then 2 ns more.
  task automatic go(input int k);
    while (cyc < base + k) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic set_sw(input logic l, input logic r, input logic b, input logic h);
    bus.left = l; bus.right = r; bus.brake = b; bus.hazard = h;
  endtask

  // Monitor: compare every expectation that has come due, away from the clock edge.
  exp_t m;
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].k <= cyc) begin
      m = q.pop_front();
      checks++;
      if (m.k < cyc) begin
        errors++;
        $display("FAIL %s: sample missed at cycle %0d, due at %0d", m.name, cyc, m.k);
      end else if (bus.current_state !== m.st || bus.count_lb !== m.lb ||
                   bus.count_rb !== m.rb || bus.count_h !== m.h) begin
        errors++;
        $display("FAIL %s: got state=%b lb=%0d rb=%0d h=%0d, expected state=%b lb=%0d rb=%0d h=%0d",
                 m.name, bus.current_state, bus.count_lb, bus.count_rb, bus.count_h,
                 m.st, m.lb, m.rb, m.h);
      end
    end
  end

  initial begin
    reset = 1'b1;
    set_sw(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    base = cyc;

    // Reset state, then left only: LEFT after 1+LAT edges, lb steps on ticks (edges 4,8,..).
    push(0,       3'b000, 0, 0, 0, "reset_state");
    push(1 + LAT, 3'b001, 0, 0, 0, "left_entry");
    push(4,       3'b001, 1, 0, 0, "left_lb1");
    push(7,       3'b001, 1, 0, 0, "left_hold1");
    push(8,       3'b001, 2, 0, 0, "left_lb2");
    push(12,      3'b001, 3, 0, 0, "left_lb3");
    push(16,      3'b001, 0, 0, 0, "left_wrap");
    push(20,      3'b001, 1, 0, 0, "left_lb1b");
    push(24,      3'b001, 2, 0, 0, "left_lb2b");
    reset = 1'b0;
    set_sw(1, 0, 0, 0);

    // Brake with lb=2: LBREAK, counter kept, then 3 on the next tick.
    push(27, 3'b011, 2, 0, 0, "lbreak_keep");
    push(28, 3'b011, 3, 0, 0, "lbreak_inc");
    go(24);
    set_sw(1, 0, 1, 0);

    // Hazard with all switches: HAZARD, h toggles per tick, lb cleared.
    push(31, 3'b110, 0, 0, 0, "hazard_entry");
    push(32, 3'b110, 0, 0, 1, "hazard_h1");
    push(36, 3'b110, 0, 0, 0, "hazard_h0");
    push(40, 3'b110, 0, 0, 1, "hazard_h1b");
    go(28);
    set_sw(1, 1, 1, 1);

    // Hazard off, brake on with both turns: BREAK, h cleared.
    push(43, 3'b101, 0, 0, 0, "break_from_haz");
    push(44, 3'b101, 0, 0, 0, "break_tick");
    go(40);
    set_sw(1, 1, 1, 0);

    // Both turns without brake -> IDEL; with brake -> BREAK.
    push(47, 3'b000, 0, 0, 0, "lr_nobrake");
    go(44);
    set_sw(1, 1, 0, 0);
    push(51, 3'b101, 0, 0, 0, "lr_brake");
    go(48);
    set_sw(1, 1, 1, 0);

    // LEFT again, then switch to RIGHT so the state changes on a tick edge (60).
    push(55, 3'b001, 0, 0, 0, "left_again");
    push(56, 3'b001, 1, 0, 0, "left_again_lb1");
    push(59, 3'b001, 1, 0, 0, "left_before_sw");
    go(52);
    set_sw(1, 0, 0, 0);
    push(60, 3'b010, 0, 0, 0, "l2r_on_tick");
    push(64, 3'b010, 0, 1, 0, "right_rb1");
    push(68, 3'b010, 0, 2, 0, "right_rb2");
    push(72, 3'b010, 0, 3, 0, "right_rb3");
    go(59 - LAT);
    set_sw(0, 1, 0, 0);

    // Asynchronous reset mid-cycle with rb=3: outputs clear before the next edge.
    push(73, 3'b000, 0, 0, 0, "async_reset");
    push(74, 3'b000, 0, 0, 0, "reset_hold");
    go(73);
    reset = 1'b1;
    go(75);
    base = cyc;
    push(3, 3'b010, 0, 0, 0, "post_reset_right");
    push(4, 3'b010, 0, 1, 0, "post_reset_tick");
    reset = 1'b0;

    for (int i = 0; i < 40 && q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations never checked, required 0", q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
